// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: issues one instruction-memory read at a time,
// holds the fetched word for the fetch stage, and squashes results on redirect.
module instr_fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic        pipe_freeze,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        fetch_stall
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [DATA_W-1:0]   instr_d;
    logic                valid_d;
    logic [ADDR_W-1:0]   drop_addr;
    logic [ADDR_W-1:0]   drop_addr_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            instruction <= DATA_W'(0);
            instr_valid <= 1'b0;
            drop_addr   <= ADDR_W'(0);
        end else begin
            state       <= state_d;
            instruction <= instr_d;
            instr_valid <= valid_d;
            drop_addr   <= drop_addr_d;
        end
    end

    // Next-state, next-data and request outputs
    always_comb begin
        state_d     = state;
        instr_d     = instruction;
        valid_d     = instr_valid;
        drop_addr_d = drop_addr;
        mem_req     = 1'b0;
        mem_addr    = pc;

        unique case (state)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (branch_taken) begin
                    valid_d = 1'b0;
                    if (!mem_ack) begin
                        // Request cannot be withdrawn; remember its address
                        drop_addr_d = pc;
                        state_d     = DROP;
                    end
                end else if (mem_ack) begin
                    instr_d = mem_rdata;
                    valid_d = 1'b1;
                    state_d = READY;
                end
            end
            READY: begin
                if (branch_taken || !pipe_freeze) begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            DROP: begin
                mem_req  = 1'b1;
                mem_addr = drop_addr;
                valid_d  = 1'b0;
                if (mem_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fetch_stall = !branch_taken && ((state != READY) || pipe_freeze);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios then random
// traffic, compared each cycle against a transaction-level fetch model.
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        branch_taken;
    logic        pipe_freeze;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        fetch_stall;

    int n_checks = 0;
    int n_err    = 0;

    // Model: "starting" after reset, an open request, whether it was squashed,
    // the squashed request's address, and the word held for the fetch stage.
    logic        m_known;
    logic        m_starting;
    logic        m_open;
    logic        m_squash;
    logic [31:0] m_latch;
    logic [31:0] m_word;
    logic        m_valid;
    logic [31:0] target;

    instr_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .branch_taken (branch_taken),
        .pipe_freeze  (pipe_freeze),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .fetch_stall  (fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance.
    task automatic cyc(input logic r, input logic b, input logic f, input logic a,
                       input logic [31:0] d);
        logic exp_req;
        logic exp_stall;
        logic [31:0] exp_addr;
        rst = r; branch_taken = b; pipe_freeze = f; mem_ack = a; mem_rdata = d;
        #1;
        exp_req   = m_open;
        exp_addr  = m_squash ? m_latch : pc;
        exp_stall = !b && (!m_valid || f);
        if (m_known) begin
            chk("mem_req", 32'(mem_req), 32'(exp_req));
            if (exp_req) chk("mem_addr", mem_addr, exp_addr);
            chk("fetch_stall", 32'(fetch_stall), 32'(exp_stall));
            chk("instruction", instruction, m_word);
            chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_known = 1'b1; m_starting = 1'b1; m_open = 1'b0; m_squash = 1'b0;
            m_latch = 32'h0; m_word = 32'h0; m_valid = 1'b0;
        end else if (m_starting) begin
            m_starting = 1'b0;
            m_open     = 1'b1;
        end else if (m_open && m_squash) begin
            if (a) m_squash = 1'b0;
        end else if (m_open) begin
            if (b && !a) begin
                m_squash = 1'b1;
                m_latch  = pc;
            end else if (!b && a) begin
                m_word  = d;
                m_valid = 1'b1;
                m_open  = 1'b0;
            end
        end else if (b || !f) begin
            m_valid = 1'b0;
            m_open  = 1'b1;
        end
        if (!exp_stall) pc = b ? target : pc + 32'd1;
        @(negedge clk);
    endtask

    initial begin
        m_known = 1'b0; m_starting = 1'b0; m_open = 1'b0; m_squash = 1'b0;
        m_latch = 32'h0; m_word = 32'h0; m_valid = 1'b0; target = 32'h0;
        rst = 1'b1; pc = 32'h0; branch_taken = 1'b0; pipe_freeze = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);

        // Reset and idle behaviour
        cyc(1, 0, 0, 0, 32'h0);
        cyc(1, 0, 0, 1, 32'h5);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_stall", 32'(fetch_stall), 32'h1);
        cyc(0, 0, 0, 1, 32'h77);

        // Zero-wait memory, pc 0..3
        for (int i = 0; i < 4; i++) begin
            chk("zw_addr", mem_addr, 32'(i));
            cyc(0, 0, 0, 1, 32'h100 + 32'(i));
            chk("zw_valid", 32'(instr_valid), 32'h1);
            chk("zw_word", instruction, 32'h100 + 32'(i));
            cyc(0, 0, 0, 1, 32'hBAD);
            chk("zw_valid_drop", 32'(instr_valid), 32'h0);
        end

        // Three-cycle ack latency at pc=5
        pc = 32'd5;
        cyc(0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0);
        chk("lat_req", 32'(mem_req), 32'h1);
        cyc(0, 0, 0, 1, 32'hE3A01005);
        chk("lat_word", instruction, 32'hE3A01005);
        cyc(0, 0, 0, 0, 32'h0);

        // Freeze with a held word
        cyc(0, 0, 0, 1, 32'h11111111);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 32'h0);
        chk("frz_word", instruction, 32'h11111111);
        chk("frz_valid", 32'(instr_valid), 32'h1);
        cyc(0, 0, 0, 0, 32'h0);
        chk("frz_resume_req", 32'(mem_req), 32'h1);

        // Branch during a pending fetch: squashed address held until ack
        pc = 32'd8; target = 32'd40;
        cyc(0, 1, 0, 0, 32'h0);
        chk("drop_addr", mem_addr, 32'd8);
        cyc(0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 1, 32'hDEADBEEF);
        chk("drop_next_addr", mem_addr, 32'd40);
        chk("drop_no_valid", 32'(instr_valid), 32'h0);

        // Branch coinciding with ack, then branch in READY under freeze
        target = 32'd60;
        cyc(0, 1, 0, 1, 32'hCAFE0001);
        chk("bt_ack_valid", 32'(instr_valid), 32'h0);
        chk("bt_ack_addr", mem_addr, 32'd60);
        cyc(0, 0, 0, 1, 32'hCAFE0002);
        target = 32'd80;
        cyc(0, 1, 1, 0, 32'h0);
        chk("bt_ready_addr", mem_addr, 32'd80);

        // Reset mid-fetch
        cyc(0, 0, 0, 0, 32'h0);
        cyc(1, 0, 0, 0, 32'h0);
        chk("rst_mid_req", 32'(mem_req), 32'h0);
        cyc(0, 0, 0, 1, 32'h0);
        chk("rst_resume_req", 32'(mem_req), 32'h1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, b, f, a;
            r = 1'($urandom_range(0, 99) == 0);
            b = 1'($urandom_range(0, 7) == 0);
            f = 1'($urandom_range(0, 1));
            a = 1'($urandom_range(0, 2) == 0);
            if (b) target = $urandom;
            cyc(r, b, f, a, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
